gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//  Shares the single register port of GPIO_Slave (i_WEnable/i_WAddr/i_WData, i_REnable/i_RAddr/o_RData, o_Err)
//  among NUM_REQ bus masters (CPU core, debug bridge, DMA). Round-robin arbitration, one transaction in
//  flight at a time. Each master gets a req/done handshake and the completed read data plus error flag.
//  Sits between the SoC interconnect and GPIO_Slave. The slave itself is unchanged.
// PARAMETERS
//  NUM_REQ    2   number of requesting masters (2..8)
//  ADDR_W     32  address width, passed straight through to the slave
//  DATA_W     32  write/read data width
//  RD_LAT     1   slave read latency in cycles: o_RData is valid RD_LAT cycles after the i_REnable cycle (1..4)
// PORTS
//  i_Clk       in   1               system clock, rising edge
//  i_Rst       in   1               reset: synchronous, active-high
//  i_Req       in   NUM_REQ         per-master request; held high until the matching o_Done
//  i_ReqWr     in   NUM_REQ         per-master direction: 1 = write, 0 = read
//  i_ReqAddr   in   NUM_REQ*ADDR_W  per-master address, packed, master n at [n*ADDR_W +: ADDR_W]
//  i_ReqWData  in   NUM_REQ*DATA_W  per-master write data, packed the same way
//  o_Gnt       out  NUM_REQ         one-hot, 1-cycle pulse: request captured
//  o_Done      out  NUM_REQ         one-hot, 1-cycle pulse: transaction complete
//  o_RData     out  DATA_W          read data; valid only in the o_Done cycle of a read, 0 otherwise
//  o_Err       out  1               slave error; valid only in the o_Done cycle
//  o_Busy      out  1               high in every state other than IDLE
//  o_WEnable   out  1               to slave i_WEnable
//  o_WAddr     out  ADDR_W          to slave i_WAddr
//  o_WData     out  DATA_W          to slave i_WData
//  o_REnable   out  1               to slave i_REnable
//  o_RAddr     out  ADDR_W          to slave i_RAddr
//  i_RData     in   DATA_W          from slave o_RData
//  i_Err       in   1               from slave o_Err
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; round-robin pointer to 0. Reset mid-transaction aborts it with no o_Done.
//  FSM:
//   IDLE: if |i_Req, the winner is the first set bit at or after the pointer, wrapping modulo NUM_REQ.
//         Latch its wr/addr/wdata/index. Pulse o_Gnt[idx]. Go to ISSUE.
//   ISSUE: exactly one cycle of o_WEnable=1 (write) or o_REnable=1 (read), with the latched addr/data.
//          Write -> DONE. Read -> WAIT with counter = RD_LAT-1.
//   WAIT: decrement the counter. When it reaches 0, register i_RData and i_Err, then go to DONE.
//         RD_LAT=1 gives exactly one WAIT cycle.
//   DONE: pulse o_Done[idx] with the registered o_RData/o_Err. Pointer = (idx+1) mod NUM_REQ. Go to IDLE.
//  Write error: i_Err is sampled in the cycle after ISSUE (the DONE transition) and presented in DONE.
//  Latency from the request being seen in IDLE to o_Done: write = 3 cycles; read = 3+RD_LAT cycles.
//  o_Gnt is asserted in the IDLE->ISSUE cycle.
//  Back-to-back: the cycle after DONE is IDLE, so a request already pending is granted in that cycle.
//  Address, data and enable outputs hold their last values when idle; only the enables return to 0.
//  Simultaneous requests: strict round-robin. A master with a continuously held request is served
//  within NUM_REQ transactions.
//  Request dropped after grant: the transaction still completes and o_Done still pulses.
//  i_Req changes outside IDLE are ignored.
//  The pointer advances only on DONE; reset is the only other thing that changes it.
//  The index is $clog2(NUM_REQ) bits wide. The pointer wrap is an explicit compare; power-of-2 overflow is not relied on.
// STRUCTURE
//  gpio_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), localparam IDX_W = $clog2(NUM_REQ), RD_LAT bounds.
//  Sub-module gpio_rr_picker: combinational; inputs req vector and pointer; outputs one-hot grant, index, any.
//  Everything else (FSM, capture registers, latency counter) lives in gpio_bus_arbiter.
// TESTING
//  1. Reset then idle: all outputs 0, o_Busy 0 for 10 cycles with i_Req=0.
//  2. Master 0 writes addr 1, data 0x0F (direction register):
//     o_Gnt=01; next cycle o_WEnable=1 with WAddr=1, WData=0x0F; o_Done=01 two cycles later; o_Err=0.
//  3. Master 1 reads addr 0 after a write of 0x55 to addr 0, RD_LAT=1: o_Done=10 with o_RData=0x55.
//  4. Both masters request continuously, 6 transactions: grant order 0,1,0,1,0,1 with no idle gap
//     other than the single IDLE cycle.
//  5. Master 0 reads an unmapped addr 7 while the slave raises o_Err: o_Done=01, o_Err=1, o_RData=0.
//  6. i_Rst asserted during WAIT: no o_Done. After release, a master 1 request is granted first
//     (pointer is back at 0, master 0 idle).

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types, bounds and helpers for the GPIO register-port arbiter
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;
    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 4;

    // Counter holds RD_LAT-1, so it only has to reach RD_LAT_MAX-1
    localparam int CNT_W = $clog2(RD_LAT_MAX);

    // Wrap a requester index back into 0..n-1 with an explicit compare
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/gpio_rr_picker.sv
// gpio_rr_picker: combinational round-robin choice of the first request at or after the pointer
module gpio_rr_picker
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from the pointer upward, wrapping, and keep the first hit
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[rr_wrap(int'(ptr) + k, NUM_REQ)]) begin
                any = 1'b1;
                idx = IDX_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
            end
        end
    end

    assign gnt = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin sharing of the GPIO slave register port, one transaction at a time
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [NUM_REQ-1:0]        i_ReqWr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] i_ReqWData,
    output logic [NUM_REQ-1:0]        o_Gnt,
    output logic [NUM_REQ-1:0]        o_Done,
    output logic [DATA_W-1:0]         o_RData,
    output logic                      o_Err,
    output logic                      o_Busy,
    output logic                      o_WEnable,
    output logic [ADDR_W-1:0]         o_WAddr,
    output logic [DATA_W-1:0]         o_WData,
    output logic                      o_REnable,
    output logic [ADDR_W-1:0]         o_RAddr,
    input  logic [DATA_W-1:0]         i_RData,
    input  logic                      i_Err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               take;

    gpio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (i_Req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign take = (state == IDLE) && pick_any;

    // Next state: requests only matter in IDLE, a read waits out the slave latency
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pick_any ? ISSUE : IDLE;
            ISSUE:   state_n = wr_q ? DONE : WAIT;
            WAIT:    state_n = (cnt == '0) ? DONE : WAIT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and round-robin pointer; the pointer moves only when a transaction completes
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            if (state == DONE)
                ptr <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Capture the winner's request and the slave response; bus address/data hold between transactions
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            o_WAddr <= '0;
            o_WData <= '0;
            o_RAddr <= '0;
        end else begin
            if (take) begin
                idx_q <= pick_idx;
                wr_q  <= i_ReqWr[pick_idx];
                if (i_ReqWr[pick_idx]) begin
                    o_WAddr <= i_ReqAddr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    o_WData <= i_ReqWData[int'(pick_idx)*DATA_W +: DATA_W];
                end else begin
                    o_RAddr <= i_ReqAddr[int'(pick_idx)*ADDR_W +: ADDR_W];
                end
            end
            if (state == ISSUE) begin
                cnt     <= CNT_W'(RD_LAT - 1);
                err_q   <= i_Err;
                rdata_q <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    rdata_q <= i_RData;
                    err_q   <= i_Err;
                end
            end
        end
    end

    assign o_Gnt     = (take && !i_Rst) ? pick_gnt : '0;
    assign o_WEnable = (state == ISSUE) && wr_q;
    assign o_REnable = (state == ISSUE) && !wr_q;
    assign o_Done    = (state == DONE) ? (NUM_REQ'(1) << idx_q) : '0;
    assign o_RData   = (state == DONE && !wr_q) ? rdata_q : '0;
    assign o_Err     = (state == DONE) && err_q;
    assign o_Busy    = (state != IDLE);

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed scoreboard bench for the GPIO register-port arbiter
module tb_gpio_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int RD_LAT  = 1;

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        req_wr = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      busy;
    logic                      wen;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic                      ren;
    logic [ADDR_W-1:0]         raddr;
    logic [DATA_W-1:0]         s_rdata = '0;
    logic                      s_rerr = 1'b0;
    logic                      s_err;
    logic [31:0]               mem [8];

    int   total = 0;
    int   bad = 0;
    int   gnt_q[$];
    exp_t done_q[$];
    int   mon_g;
    exp_t mon_d;

    always #5 clk = ~clk;

    gpio_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Req      (req),
        .i_ReqWr    (req_wr),
        .i_ReqAddr  (req_addr),
        .i_ReqWData (req_wdata),
        .o_Gnt      (gnt),
        .o_Done     (done),
        .o_RData    (rdata),
        .o_Err      (err),
        .o_Busy     (busy),
        .o_WEnable  (wen),
        .o_WAddr    (waddr),
        .o_WData    (wdata),
        .o_REnable  (ren),
        .o_RAddr    (raddr),
        .i_RData    (s_rdata),
        .i_Err      (s_err)
    );

    // Slave model: addresses 0..6 are registers, 7 and above raise an error; reads take one cycle
    always @(posedge clk) begin
        if (wen && waddr < 7) mem[waddr[2:0]] <= wdata;
        s_rdata <= (ren && raddr < 7) ? mem[raddr[2:0]] : '0;
        s_rerr  <= ren && (raddr >= 7);
    end
    assign s_err = (wen && waddr >= 7) || s_rerr;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard: every grant and completion is matched against the queued expectation
    always @(negedge clk) begin
        if (gnt != '0) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", gnt, 0);
            else begin
                mon_g = gnt_q.pop_front();
                chk("gnt", gnt, onehot(mon_g));
            end
        end
        if (done != '0) begin
            if (done_q.size() == 0) chk("done_unexpected", done, 0);
            else begin
                mon_d = done_q.pop_front();
                chk("done_idx", done, onehot(mon_d.idx));
                chk("done_rdata", rdata, mon_d.rd);
                chk("done_err", err, mon_d.err);
            end
        end
    end

    task automatic set_master(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_wr[m] = wr;
        req_addr[m*ADDR_W +: ADDR_W] = addr;
        req_wdata[m*DATA_W +: DATA_W] = data;
    endtask

    task automatic run_txn(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(posedge clk) #1;
        set_master(m, wr, addr, data);
        req[m] = 1'b1;
        gnt_q.push_back(m);
        done_q.push_back('{m, exp_rd, exp_err});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[m] && n < 20);
        chk(wr ? "lat_wr" : "lat_rd", n, wr ? 3 : 3 + RD_LAT);
        req[m] = 1'b0;
    endtask

    task automatic pair_writes(input int n);
        int got, last, cyc;
        @(posedge clk) #1;
        for (int k = 0; k < n; k++) begin
            gnt_q.push_back(k % 2);
            done_q.push_back('{k % 2, 32'h0, 1'b0});
        end
        set_master(0, 1'b1, 32'd2, 32'h22);
        set_master(1, 1'b1, 32'd3, 32'h33);
        req = 2'b11;
        got = 0;
        last = 0;
        cyc = 0;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                got++;
                if (got > 1) chk("pair_gap", cyc - last, 3);
                last = cyc;
                if (got == n) req = '0;
            end
        end
        req = '0;
        chk("pair_count", got, n);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        // Reset, then idle with no requests
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_outs", {gnt, done, rdata, err, wen, waddr, wdata, ren, raddr}, 0);
        end
        // Master 0 writes 0x0F to the direction register, cycle by cycle
        @(posedge clk) #1;
        set_master(0, 1'b1, 32'd1, 32'h0F);
        req[0] = 1'b1;
        gnt_q.push_back(0);
        done_q.push_back('{0, 32'h0, 1'b0});
        @(negedge clk);
        chk("t2_gnt", gnt, 2'b01);
        @(negedge clk);
        chk("t2_issue", {wen, ren, waddr, wdata}, {1'b1, 1'b0, 32'd1, 32'h0F});
        @(negedge clk);
        chk("t2_done", {done, err}, {2'b01, 1'b0});
        req[0] = 1'b0;
        @(negedge clk);
        chk("t2_hold", {busy, wen, waddr, wdata}, {1'b0, 1'b0, 32'd1, 32'h0F});
        // Master 1 writes then reads back address 0
        run_txn(1, 1'b1, 32'd0, 32'h55, 32'h0, 1'b0);
        run_txn(1, 1'b0, 32'd0, 32'h0, 32'h55, 1'b0);
        // Both masters request continuously
        pair_writes(6);
        // Unmapped read raises the error and returns zero data
        run_txn(0, 1'b0, 32'd7, 32'h0, 32'h0, 1'b1);
        // Leave the pointer at 1, then reset in the middle of a read
        run_txn(0, 1'b1, 32'd4, 32'hAA, 32'h0, 1'b0);
        @(posedge clk) #1;
        set_master(1, 1'b0, 32'd0, 32'h0);
        req[1] = 1'b1;
        gnt_q.push_back(1);
        @(posedge clk) #1;
        req[1] = 1'b0;
        @(posedge clk) #1;
        chk("t6_in_wait", {busy, ren}, {1'b1, 1'b0});
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_done", {done, busy}, 0);
        end
        pair_writes(2);
        run_txn(1, 1'b0, 32'd0, 32'h0, 32'h55, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drained", gnt_q.size() + done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
